// File: rtl/alu_pkg.sv
// Shared constants for the operand-fetch / ALU boundary: default widths,
// RV32I major opcodes and funct7 values, the 5-bit ALU opcode map and a
// field view of the instruction word.
package alu_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_OP_WIDTH = 5;
    localparam int DEF_REG_AW   = 5;

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct7 encodings: base ops and the SUB/SRA alternate
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 values that need special decode treatment
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    // ALU opcode map, {funct7[5], funct3, 1'b1}; all-zero marks "no operation"
    localparam logic [4:0] ALU_NOP  = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b10001;
    localparam logic [4:0] ALU_SLL  = 5'b00011;
    localparam logic [4:0] ALU_SLT  = 5'b00101;
    localparam logic [4:0] ALU_SLTU = 5'b00111;
    localparam logic [4:0] ALU_XOR  = 5'b01001;
    localparam logic [4:0] ALU_SRL  = 5'b01011;
    localparam logic [4:0] ALU_SRA  = 5'b11011;
    localparam logic [4:0] ALU_OR   = 5'b01101;
    localparam logic [4:0] ALU_AND  = 5'b01111;

    // R/I-type field layout of a 32-bit instruction word
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv_instr_t;

endpackage

// File: rtl/reg_file.sv
// Register file: 2 asynchronous read ports, 1 synchronous write port,
// asynchronous reset of every entry, entry 0 hardwired to zero.
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data
);

    localparam int DEPTH = 2 ** REG_AW;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    // Next register contents: apply the write unless it targets x0
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a
        // default first, so no path leaves a value unassigned and infers a latch.
        regs_d = regs_q;
        if (wr_en && wr_addr != '0) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Register array with asynchronous clear of every entry
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the architected state must read zero after reset, so this array is
        // reset entry by entry (flops, not a RAM macro); state updates use '<='.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage in front of the 32-bit ALU: decodes RV32I R/I-type ALU
// instructions, reads rs1/rs2, and holds opcode/operands in a valid/ready
// output register.
// Build option: define WB_BYPASS_EN to forward a same-cycle writeback into
// the captured operands; otherwise operands are the pre-write register values.
module operand_fetch
    import alu_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int OP_WIDTH = DEF_OP_WIDTH,
    parameter int REG_AW   = DEF_REG_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic                wb_en,
    input  logic [REG_AW-1:0]   wb_addr,
    input  logic [WIDTH-1:0]    wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_WIDTH-1:0] out_opcode,
    output logic [WIDTH-1:0]    out_a,
    output logic [WIDTH-1:0]    out_b,
    output logic [REG_AW-1:0]   out_rd,
    output logic                out_illegal
);

    rv_instr_t         instr;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [WIDTH-1:0]  rf_a;
    logic [WIDTH-1:0]  rf_b;
    logic [WIDTH-1:0]  rs1_val;
    logic [WIDTH-1:0]  rs2_val;
    logic              accept;

    logic                dec_illegal;
    logic [OP_WIDTH-1:0] dec_opcode;
    logic                dec_use_imm;
    logic [WIDTH-1:0]    dec_imm;

    logic                out_valid_d,   out_valid_q;
    logic [OP_WIDTH-1:0] out_opcode_d,  out_opcode_q;
    logic [WIDTH-1:0]    out_a_d,       out_a_q;
    logic [WIDTH-1:0]    out_b_d,       out_b_q;
    logic [REG_AW-1:0]   out_rd_d,      out_rd_q;
    logic                out_illegal_d, out_illegal_q;

    assign instr    = rv_instr_t'(in_instr);
    assign rs1_addr = REG_AW'(instr.rs1);
    assign rs2_addr = REG_AW'(instr.rs2);

    reg_file #(
        .WIDTH  (WIDTH),
        .REG_AW (REG_AW)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rs1_addr),
        .rd_data_a (rf_a),
        .rd_addr_b (rs2_addr),
        .rd_data_b (rf_b),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

    // Source operand values, optionally forwarding a same-cycle writeback
    always_comb begin
        rs1_val = rf_a;
        rs2_val = rf_b;
`ifdef WB_BYPASS_EN
        if (wb_en && wb_addr != '0 && wb_addr == rs1_addr) begin
            rs1_val = wb_data;
        end
        if (wb_en && wb_addr != '0 && wb_addr == rs2_addr) begin
            rs2_val = wb_data;
        end
`endif
    end

    // Instruction decode: legality, ALU opcode and immediate selection
    always_comb begin
        dec_illegal = 1'b1;
        dec_opcode  = ALU_NOP;
        dec_use_imm = 1'b0;
        dec_imm     = '0;
        case (instr.opcode)
            OPC_OP: begin
                // Alternate funct7 only exists for SUB and SRA
                if (instr.funct7 == F7_BASE ||
                    (instr.funct7 == F7_ALT &&
                     (instr.funct3 == F3_ADD || instr.funct3 == F3_SR))) begin
                    dec_illegal = 1'b0;
                    dec_opcode  = {instr.funct7[5], instr.funct3, 1'b1};
                end
            end
            OPC_OP_IMM: begin
                dec_use_imm = 1'b1;
                if (instr.funct3 == F3_SLL || instr.funct3 == F3_SR) begin
                    // Shift-immediate: upper bits carry funct7, low five the shamt
                    dec_imm = WIDTH'(instr.rs2);
                    if (instr.funct7 == F7_BASE || instr.funct7 == F7_ALT) begin
                        dec_illegal = 1'b0;
                        dec_opcode  = {(instr.funct3 == F3_SR) & instr.funct7[5],
                                       instr.funct3, 1'b1};
                    end
                end else begin
                    dec_imm     = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};
                    dec_illegal = 1'b0;
                    dec_opcode  = {1'b0, instr.funct3, 1'b1};
                end
            end
            default: ;
        endcase
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Output register next state: load on accept, drop valid on consume, else hold
    always_comb begin
        out_valid_d   = out_valid_q;
        out_opcode_d  = out_opcode_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_rd_d      = out_rd_q;
        out_illegal_d = out_illegal_q;
        if (accept) begin
            out_valid_d = 1'b1;
            if (dec_illegal) begin
                // Illegal ops travel as a zeroed no-op the ALU result is dropped for
                out_illegal_d = 1'b1;
                out_opcode_d  = '0;
                out_a_d       = '0;
                out_b_d       = '0;
                out_rd_d      = '0;
            end else begin
                out_illegal_d = 1'b0;
                out_opcode_d  = dec_opcode;
                out_a_d       = rs1_val;
                out_b_d       = dec_use_imm ? dec_imm : rs2_val;
                out_rd_d      = REG_AW'(instr.rd);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output pipeline register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_opcode_q  <= '0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_rd_q      <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_opcode_q  <= out_opcode_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_rd_q      <= out_rd_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_opcode  = out_opcode_q;
    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_illegal_q;

endmodule
